instr_dispatch: RTL

Sequential instruction fetch/dispatch controller that sits directly upstream of the per-class execution FSMs (register ALU, immediate ALU, memory). It fetches an 18-bit instruction word from instruction memory at the program counter and splits it into opcode / param1 / param2 fields. It then issues a one-cycle start to exactly one execution FSM and waits for that FSM's `done` before advancing the PC. A watchdog flags any execution FSM that never completes.

---
 rtl/ssm_dispatch_pkg.sv | 38 +++
 rtl/instr_dispatch_watchdog.sv | 31 +++
 rtl/instr_dispatch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ssm_dispatch_pkg.sv
// Shared definitions for the instruction dispatch controller: instruction
// field layout, class/opcode codes and the controller state encoding.
package ssm_dispatch_pkg;

  localparam int INSTR_W = 18;

  // Instruction word layout: [17:16] class, [15:12] opcode, [11:6] p1, [5:0] p2
  localparam int CLS_HI = 17;
  localparam int CLS_LO = 16;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int P1_HI  = 11;
  localparam int P1_LO  = 6;
  localparam int P2_HI  = 5;
  localparam int P2_LO  = 0;

  typedef enum logic [1:0] {
    CLS_REG = 2'b00,
    CLS_IMM = 2'b01,
    CLS_MEM = 2'b10,
    CLS_SYS = 2'b11
  } cls_e;

  // System class: opcode 0 is NOP, anything else halts
  localparam logic [3:0] SYS_NOP = 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_HALTED,
    S_ERROR
  } state_e;

endpackage

// File: rtl/instr_dispatch_watchdog.sv
// 8-bit watchdog for the WAIT state: cleared when an instruction is issued,
// counts while enabled, flags the edge on which the count reaches TIMEOUT.
module dispatch_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear wins over enable
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = 8'd0;
    else if (en_i) cnt_d = cnt_q + 8'd1;
  end

  // Count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  // High in the cycle whose closing edge brings the count to TIMEOUT
  assign expired_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/instr_dispatch.sv
// Fetch/decode/dispatch controller: fetches one instruction per pass, issues a
// single start pulse to the matching execution FSM, waits for its done, then
// advances the PC. All outputs are decoded from registered state.
module instr_dispatch
  import ssm_dispatch_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_valid,
  input  logic               done_reg,
  input  logic               done_imm,
  input  logic               done_mem,
  output logic [PC_W-1:0]    pc,
  output logic               instr_rd_en,
  output logic               start_reg,
  output logic               start_imm,
  output logic               start_mem,
  output logic [3:0]         opcode,
  output logic [5:0]         param1,
  output logic [5:0]         param2,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [15:0]        retired
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [15:0]        ret_q, ret_d;
  cls_e               cls;
  logic [3:0]         op;
  logic               sel_done;
  logic               wd_expired;

  assign cls = cls_e'(ir_q[CLS_HI:CLS_LO]);
  assign op  = ir_q[OP_HI:OP_LO];

  dispatch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (state_q == S_ISSUE),
    .en_i      (state_q == S_WAIT),
    .expired_o (wd_expired)
  );

  // Only the done of the FSM that was started may complete the instruction
  always_comb begin
    case (cls)
      CLS_REG: sel_done = done_reg;
      CLS_IMM: sel_done = done_imm;
      CLS_MEM: sel_done = done_mem;
      default: sel_done = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; done takes priority over a same-cycle watchdog expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (cls != CLS_SYS)    state_d = S_ISSUE;
        else if (op == SYS_NOP) state_d = S_NEXT;
        else                    state_d = S_HALTED;
      end
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (sel_done)        state_d = S_NEXT;
        else if (wd_expired) state_d = S_ERROR;
      end
      S_NEXT:   state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = state_q;
    endcase
  end

  // Datapath next values: capture in FETCH, advance PC/retired leaving NEXT
  always_comb begin
    ir_d  = ir_q;
    pc_d  = pc_q;
    ret_d = ret_q;
    if (state_q == S_FETCH && instr_valid) ir_d = instr_data;
    if (state_q == S_NEXT) begin
      pc_d  = pc_q + PC_W'(1);
      ret_d = ret_q + 16'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_q  <= '0;
      pc_q  <= '0;
      ret_q <= '0;
    end else begin
      ir_q  <= ir_d;
      pc_q  <= pc_d;
      ret_q <= ret_d;
    end
  end

  // Moore outputs from state and the instruction register
  always_comb begin
    instr_rd_en = 1'b0;
    start_reg   = 1'b0;
    start_imm   = 1'b0;
    start_mem   = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    error       = 1'b0;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_FETCH:  instr_rd_en = 1'b1;
      S_ISSUE: begin
        start_reg = (cls == CLS_REG);
        start_imm = (cls == CLS_IMM);
        start_mem = (cls == CLS_MEM);
      end
      S_HALTED: begin busy = 1'b0; halted = 1'b1; end
      S_ERROR:  begin busy = 1'b0; error  = 1'b1; end
      default:  ;
    endcase
    pc      = pc_q;
    retired = ret_q;
    opcode  = ir_q[OP_HI:OP_LO];
    param1  = ir_q[P1_HI:P1_LO];
    param2  = ir_q[P2_HI:P2_LO];
  end

endmodule
